// File: rtl/dmem_mmio_if.sv
// Data-port bus between the core (plus TX consumer) and the data memory system.
// The master drives the core-side strobes and the consumer's tx_ready.
interface dmem_mmio_if;
    logic [15:0] d_addr;
    logic        d_oe;
    logic [15:0] d_dout;
    logic [1:0]  d_we;
    logic [15:0] d_din;
    logic [15:0] led;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output d_addr, d_oe, d_dout, d_we, tx_ready,
        input  d_din, led, tx_valid, tx_data
    );

    modport slave (
        input  d_addr, d_oe, d_dout, d_we, tx_ready,
        output d_din, led, tx_valid, tx_data
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data-side memory: byte-lane RAM plus an MMIO page with LED, cycle counter and TX FIFO.
// Reads are combinational; all writes and side effects commit on the rising edge.
module dmem_mmio #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
    input  logic       clk,
    input  logic       rst,
    dmem_mmio_if.slave bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam logic [16:0] RAM_BYTES = 17'(2 * RAM_WORDS);

    localparam logic [6:0] OFF_LED    = 7'd0;
    localparam logic [6:0] OFF_CNT_LO = 7'd1;
    localparam logic [6:0] OFF_CNT_HI = 7'd2;
    localparam logic [6:0] OFF_TXDATA = 7'd3;
    localparam logic [6:0] OFF_STATUS = 7'd4;

    logic [15:0] ram [RAM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [15:0] led_reg, led_next;
    logic [31:0] cnt_reg;
    logic [15:0] cnt_hi_reg, cnt_hi_next;
    logic        ovf_reg, ovf_next;
    logic [FW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [FW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;

    logic          ram_sel, mmio_sel;
    logic [AW-1:0] ram_idx;
    logic [6:0]    reg_off;
    logic [15:0]   lane_mask;
    logic          full, empty, pop, push_req, push_ok, ovf_set, ovf_clr;
    logic [7:0]    push_byte;
    logic [15:0]   status;
    logic [15:0]   rd_data;

    assign ram_sel  = ({1'b0, bus.d_addr} < RAM_BYTES);
    assign mmio_sel = !ram_sel && (bus.d_addr[15:8] == MMIO_BASE[15:8]);
    assign ram_idx  = bus.d_addr[AW:1];
    assign reg_off  = bus.d_addr[7:1];

    // d_we[0] owns the even (high) byte, d_we[1] the odd (low) byte
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_mask[15-8*gi -: 8] = {8{bus.d_we[gi]}};
        end
    endgenerate

    assign full  = (count_reg == CW'(FIFO_DEPTH));
    assign empty = (count_reg == '0);
    assign pop   = !empty && bus.tx_ready;
    assign push_req  = mmio_sel && (reg_off == OFF_TXDATA) && (bus.d_we != 2'b00);
    assign push_byte = (bus.d_we == 2'b01) ? bus.d_dout[15:8] : bus.d_dout[7:0];
    assign push_ok   = push_req && (!full || pop);
    assign ovf_set   = push_req && full && !pop;
    assign ovf_clr   = mmio_sel && (reg_off == OFF_STATUS) && bus.d_we[1] && bus.d_dout[2];

    assign status = {8'(count_reg), 5'b0, ovf_reg, empty, full};

    always_comb begin
        led_next    = led_reg;
        cnt_hi_next = cnt_hi_reg;
        ovf_next    = ovf_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;

        if (mmio_sel && (reg_off == OFF_LED))
            led_next = (led_reg & ~lane_mask) | (bus.d_dout & lane_mask);
        if (mmio_sel && (reg_off == OFF_CNT_LO) && bus.d_oe)
            cnt_hi_next = cnt_reg[31:16];

        // a dropped push and a clear in the same cycle leave ovf set
        if (ovf_set)
            ovf_next = 1'b1;
        else if (ovf_clr)
            ovf_next = 1'b0;

        if (push_ok)
            wr_ptr_next = wr_ptr_reg + 1'b1;
        if (pop)
            rd_ptr_next = rd_ptr_reg + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_reg    <= '0;
            cnt_reg    <= '0;
            cnt_hi_reg <= '0;
            ovf_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            led_reg    <= led_next;
            cnt_reg    <= cnt_reg + 32'd1;
            cnt_hi_reg <= cnt_hi_next;
            ovf_reg    <= ovf_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage arrays carry no reset; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst && ram_sel) begin
            for (int l = 0; l < 2; l++) begin
                if (bus.d_we[l])
                    ram[ram_idx][15-8*l -: 8] <= bus.d_dout[15-8*l -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            fifo_mem[wr_ptr_reg] <= push_byte;
    end

    always_comb begin
        rd_data = '0;
        if (bus.d_oe) begin
            if (ram_sel) begin
                rd_data = ram[ram_idx];
            end else if (mmio_sel) begin
                case (reg_off)
                    OFF_LED:    rd_data = led_reg;
                    OFF_CNT_LO: rd_data = cnt_reg[15:0];
                    OFF_CNT_HI: rd_data = cnt_hi_reg;
                    OFF_STATUS: rd_data = status;
                    default:    rd_data = '0;
                endcase
            end
        end
    end

    assign bus.d_din    = rd_data;
    assign bus.led      = led_reg;
    assign bus.tx_valid = !empty;
    assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr_reg];
endmodule
